// File: rtl/clock_set_ctrl.sv
// Button front-end and mode FSM for the clock/alarm set datapath.
// Optional auto-repeat on held increment buttons: define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 256
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       switch,
    input  logic       push1,
    input  logic       push2,
    input  logic       push3,
    output logic [2:0] mode,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       tgt_alarm,
    output logic       run_en,
    output logic       alarm_armed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_HR  = 3'd2,
        ST_ALM_MIN = 3'd3,
        ST_ALM_HR  = 3'd4
    } state_t;

    function automatic state_t next_set_state(input state_t s);
        case (s)
            ST_SET_MIN: return ST_SET_HR;
            ST_SET_HR:  return ST_ALM_MIN;
            ST_ALM_MIN: return ST_ALM_HR;
            default:    return ST_RUN;
        endcase
    endfunction

    logic [3:0]          raw_s, sync1_q, sync2_q;
    logic [2:0]          deb_q, deb_d, deb_dly_q, deb_dly_d, press_q, press_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic                sw_s, is_min_s, sel_press_s;
    state_t              state_q, state_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                armed_q, armed_d, inc_min_q, inc_min_d, inc_hr_q, inc_hr_d;
    logic                run_en_q, run_en_d, tgt_q, tgt_d;
    logic [2:0]          mode_q, mode_d;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RPT_DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RATE_LAST  = RW'(REPEAT_RATE - 1);
    logic          hold_s, rpt_fire_s, strobe_new_s;
    logic          rpt_act_q, rpt_act_d, rpt_first_q, rpt_first_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    assign raw_s       = {switch, push3, push2, push1};
    assign sw_s        = sync2_q[3];
    assign is_min_s    = (state_q == ST_SET_MIN) || (state_q == ST_ALM_MIN);
    assign sel_press_s = is_min_s ? press_q[1] : press_q[2];

    // Debounce: level flips once DEBOUNCE_CYCLES consecutive samples disagree with it
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    cnt_d[i] = '0;
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                    deb_d[i] = deb_q[i];
                end
            end else begin
                cnt_d[i] = '0;
                deb_d[i] = deb_q[i];
            end
        end
        deb_dly_d = deb_q;
        press_d   = deb_dly_q & ~deb_q;
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    assign hold_s     = is_min_s ? ~deb_q[1] : ~deb_q[2];
    assign rpt_fire_s = rpt_act_q && hold_s &&
                        (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST));
`endif

    // Mode FSM next state, strobes, arm flag and inactivity timeout
    always_comb begin
        state_d   = state_q;
        inc_min_d = 1'b0;
        inc_hr_d  = 1'b0;
        armed_d   = armed_q;
        tmo_d     = tmo_q;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        strobe_new_s = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                tmo_d = '0;
                if (press_q[0] && sw_s) begin
                    state_d = ST_SET_MIN;
                end else if (press_q[2]) begin
                    armed_d = ~armed_q;
                end else begin
                    armed_d = armed_q;
                end
            end
            ST_SET_MIN, ST_SET_HR, ST_ALM_MIN, ST_ALM_HR: begin
                // switch-off beats mode step, which beats an increment in the same cycle
                if (!sw_s) begin
                    state_d = ST_RUN;
                end else if (press_q[0]) begin
                    state_d = next_set_state(state_q);
                    tmo_d   = '0;
                end else if (sel_press_s) begin
                    inc_min_d = is_min_s;
                    inc_hr_d  = ~is_min_s;
                    tmo_d     = '0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
                    strobe_new_s = 1'b1;
                end else if (rpt_fire_s) begin
                    inc_min_d = is_min_s;
                    inc_hr_d  = ~is_min_s;
                    tmo_d     = '0;
`endif
                end else if (tmo_q == TMO_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                tmo_d   = '0;
            end
        endcase

        mode_d   = state_d;
        run_en_d = (state_d == ST_RUN);
        tgt_d    = (state_d == ST_ALM_MIN) || (state_d == ST_ALM_HR);
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    // Repeat timer: armed by a press strobe, dropped on release or any state change
    always_comb begin
        rpt_act_d   = 1'b0;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        if ((state_d != state_q) || !hold_s) begin
            rpt_cnt_d = '0;
        end else if (strobe_new_s) begin
            rpt_act_d   = 1'b1;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (rpt_fire_s) begin
            rpt_act_d   = 1'b1;
            rpt_first_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (rpt_act_q) begin
            rpt_act_d = 1'b1;
            rpt_cnt_d = rpt_cnt_q + RW'(1);
        end else begin
            rpt_cnt_d = rpt_cnt_q;
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_act_q   <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`endif

    // Input path, FSM state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            deb_q     <= 3'b111;
            deb_dly_q <= 3'b111;
            press_q   <= 3'b000;
            cnt_q     <= '0;
            state_q   <= ST_RUN;
            tmo_q     <= '0;
            armed_q   <= 1'b0;
            inc_min_q <= 1'b0;
            inc_hr_q  <= 1'b0;
            run_en_q  <= 1'b1;
            tgt_q     <= 1'b0;
            mode_q    <= 3'd0;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            armed_q   <= armed_d;
            inc_min_q <= inc_min_d;
            inc_hr_q  <= inc_hr_d;
            run_en_q  <= run_en_d;
            tgt_q     <= tgt_d;
            mode_q    <= mode_d;
        end
    end

    assign mode        = mode_q;
    assign inc_min     = inc_min_q;
    assign inc_hr      = inc_hr_q;
    assign tgt_alarm   = tgt_q;
    assign run_en      = run_en_q;
    assign alarm_armed = armed_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: window-based reference model feeds an
// expected-output queue that a monitor drains one entry per clock.
module tb_clock_set_ctrl;

    localparam int DB  = 4;
    localparam int TMO = 256;

    logic       clk = 1'b0;
    logic       reset_n, switch, push1, push2, push3;
    logic [2:0] mode;
    logic       inc_min, inc_hr, tgt_alarm, run_en, alarm_armed;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .switch(switch),
        .push1(push1), .push2(push2), .push3(push3),
        .mode(mode), .inc_min(inc_min), .inc_hr(inc_hr),
        .tgt_alarm(tgt_alarm), .run_en(run_en), .alarm_armed(alarm_armed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] mode;
        logic       inc_min, inc_hr, tgt, run_en, armed;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0, errors = 0;
    bit         mon_en = 1'b0;
    int         mon_idx = 0, last_min_edge = -1;
    int         dut_min_cnt = 0, dut_hr_cnt = 0;

    // reference model state
    logic [3:0] hist[$];
    int         n;
    bit         deb[3];
    int         due[3];
    int         m_mode, last;
    bit         m_armed;
    int         m_min_cnt = 0, m_hr_cnt = 0;

    function automatic void model_reset();
        hist.delete();
        n = 0;
        for (int b = 0; b < 3; b++) begin
            deb[b] = 1'b1;
            due[b] = -100;
        end
        m_mode  = 0;
        m_armed = 1'b0;
        last    = 0;
        mon_idx = 0;
    endfunction

    // raw input sampled at edge k; before reset release everything reads as idle
    function automatic logic [3:0] raw_at(input int k);
        int idx;
        idx = hist.size() - 1 - (n - k);
        if (idx < 0) return 4'hF;
        return hist[idx];
    endfunction

    function automatic void model_edge(input logic [3:0] v);
        logic [3:0] r;
        bit         p[3];
        bit         sw, flip;
        exp_t       e;
        n++;
        hist.push_back(v);
        if (hist.size() > 16) void'(hist.pop_front());
        for (int b = 0; b < 3; b++) p[b] = (due[b] == n);
        r  = raw_at(n - 2);
        sw = r[3];
        e  = '0;
        if (m_mode == 0) begin
            if (p[0] && sw) begin m_mode = 1; last = n; end
            else if (p[2]) m_armed = !m_armed;
        end else if (!sw) begin
            m_mode = 0;
        end else if (p[0]) begin
            m_mode = (m_mode == 4) ? 0 : m_mode + 1;
            last = n;
        end else if ((m_mode == 1 || m_mode == 3) && p[1]) begin
            e.inc_min = 1'b1; last = n; m_min_cnt++;
        end else if ((m_mode == 2 || m_mode == 4) && p[2]) begin
            e.inc_hr = 1'b1; last = n; m_hr_cnt++;
        end else if (n - last > TMO) begin
            m_mode = 0;
        end
        // a level is accepted when the last DB synchronised samples all disagree with it
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = 2; j <= DB + 1; j++) begin
                r = raw_at(n - j);
                if (r[b] == deb[b]) flip = 1'b0;
            end
            if (flip) begin
                deb[b] = !deb[b];
                if (!deb[b]) due[b] = n + 2;
            end
        end
        e.mode   = 3'(m_mode);
        e.run_en = (m_mode == 0);
        e.tgt    = (m_mode >= 3);
        e.armed  = m_armed;
        exp_q.push_back(e);
    endfunction

    // monitor: one expected entry per clock while enabled
    always begin : monitor
        exp_t e, got;
        @(posedge clk);
        #1;
        if (mon_en) begin
            mon_idx++;
            got = {mode, inc_min, inc_hr, tgt_alarm, run_en, alarm_armed};
            if (inc_min) begin dut_min_cnt++; last_min_edge = mon_idx; end
            if (inc_hr) dut_hr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty edge %0d got %b required an expected entry", mon_idx, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs edge %0d got mode/min/hr/tgt/run/arm=%b required %b",
                             mon_idx, got, e);
                end
            end
        end
    end

    // called at a negedge; the drive is sampled at the following posedge
    task automatic cycle(input bit p1, input bit p2, input bit p3, input bit sw);
        push1  = ~p1;
        push2  = ~p2;
        push3  = ~p3;
        switch = sw;
        model_edge({sw, ~p3, ~p2, ~p1});
        @(negedge clk);
    endtask

    task automatic press(input bit p1, input bit p2, input bit p3, input int len,
                         input int gap, input bit sw);
        for (int i = 0; i < len; i++) cycle(p1, p2, p3, sw);
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, 1'b0, sw);
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_mode"}, mode, 0);
        check({name, "_run_en"}, run_en, 1);
        check({name, "_armed"}, alarm_armed, 0);
        check({name, "_strobes"}, {inc_min, inc_hr}, 0);
        check({name, "_tgt"}, tgt_alarm, 0);
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        push1 = 1'b0; push2 = 1'b0; push3 = 1'b0; switch = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_hold");
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        press(1'b0, 1'b0, 1'b0, 0, 20, 1'b1);

        // enter SET_MIN, then glitch and a real press on push2
        press(1'b1, 1'b0, 1'b0, 8, 6, 1'b1);
        last_min_edge = -1;
        press(1'b0, 1'b1, 1'b0, 3, 10, 1'b1);
        check("glitch_no_inc_min", last_min_edge, -1);
        t = n + 1;
        press(1'b0, 1'b1, 1'b0, 10, 6, 1'b1);
        check("inc_min_latency", last_min_edge, t + DB + 3);

        // SET_HR: three hour presses, a minute press is ignored
        press(1'b1, 1'b0, 1'b0, 6, 6, 1'b1);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1, 6, 5, 1'b1);
        press(1'b0, 1'b1, 1'b0, 6, 8, 1'b1);
        // walk through ALM_MIN, ALM_HR back to RUN
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, 5, 6, 1'b1);
        // RUN: arm toggle, minute ignored, mode press with switch off ignored
        press(1'b0, 1'b0, 1'b1, 6, 6, 1'b1);
        press(1'b0, 1'b1, 1'b0, 6, 6, 1'b1);
        press(1'b1, 1'b0, 1'b0, 6, 8, 1'b0);

        // simultaneous mode+minute in SET_MIN, then switch-off in ALM_MIN
        press(1'b1, 1'b0, 1'b0, 6, 6, 1'b1);
        press(1'b1, 1'b1, 1'b0, 6, 6, 1'b1);
        press(1'b1, 1'b0, 1'b0, 6, 6, 1'b1);
        press(1'b0, 1'b0, 1'b0, 0, 6, 1'b0);
        press(1'b0, 1'b0, 1'b0, 0, 4, 1'b1);

        // inactivity timeout from SET_MIN
        press(1'b1, 1'b0, 1'b0, 6, 300, 1'b1);

        // randomized presses with occasional switch-off
        for (int k = 0; k < 150; k++) begin
            press(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(1, 12),
                  $urandom_range(1, 10), ($urandom_range(0, 9) != 0));
        end

        // reset in the middle of a minute press about to strobe
        press(1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
        if (m_mode == 0) press(1'b1, 1'b0, 1'b0, 6, 6, 1'b1);
        press(1'b0, 1'b1, 1'b0, DB + 3, 0, 1'b1);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset("reset_midop");
        push1 = 1'b1; push2 = 1'b1; push3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        press(1'b0, 1'b0, 1'b0, 0, 12, 1'b1);
        mon_en = 1'b0;
        @(negedge clk);

        check("total_inc_min", dut_min_cnt, m_min_cnt);
        check("total_inc_hr", dut_hr_cnt, m_hr_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
